mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit that sequences the CPU datapath (IR, register file, ALU, data memory, PC) one instruction at a time. It decodes OP/func from the instruction register, steps a Moore FSM through fetch/decode/execute/memory/write-back, drives every datapath enable and select, and owns the ZF/OF flag register. It replaces the purely combinational R-type decode so that the datapath can add I-type, load/store, branch and jump instructions.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- OP  in  6  IR[31:26], stable from the cycle after FETCH.
- func  in  6  IR[5:0].
- ZF  in  1  live ALU zero flag.
- OF  in  1  live ALU overflow flag.
- PC_Write  out  1  PC load enable.
- PC_s  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
- IR_Write  out  1  IR load enable.
- Write_Reg  out  1  register-file write enable.
- w_r_s  out  2  write address: 00 Rd, 01 Rt.
- wr_data_s  out  1  write data: 0 ALU_F, 1 memory read data.
- rt_imm_s  out  1  ALU B: 0 Rt data, 1 extended immediate.
- imm_s  out  1  extension: 0 zero-extend, 1 sign-extend.
- ALU_OP  out  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLTU, 111 SLL.
- Mem_Write  out  1  data memory write enable.
- FR_ZF, FR_OF  out  1 each  registered flags.
- Illegal  out  1  one-cycle pulse on an unsupported instruction.
- state  out  4  current state code, for debug.

## Operation
- States (code): IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, WB_R 4, EXEC_I 5, WB_I 6, MEM_ADDR 7, MEM_RD 8, WB_LW 9, MEM_WR 10, BEQ 11, JUMP 12.
- Outputs default to 0 in every state. Each state sets only the signals listed for it.
- IDLE: goes to FETCH.
- FETCH: IR_Write=1, PC_Write=1, PC_s=00. Goes to DECODE.
- DECODE: chooses the next state from OP.
  - 000000 with func in {100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101011 sltu, 000100 sllv} goes to EXEC_R.
  - 001000 addi, 001100 andi, 001101 ori, 001110 xori, 001011 sltiu go to EXEC_I.
  - 100011 lw and 101011 sw go to MEM_ADDR.
  - 000100 beq goes to BEQ.
  - 000010 j goes to JUMP.
  - Anything else, including an unlisted func: Illegal=1 and go to FETCH. There is no register or memory write.
- EXEC_R: ALU_OP from func (add 100, sub 101, and 000, or 001, xor 010, nor 011, sltu 110, sllv 111), rt_imm_s=0. Goes to WB_R.
- WB_R: ALU controls held, Write_Reg=1, w_r_s=00, wr_data_s=0. Goes to FETCH.
- EXEC_I: rt_imm_s=1.
  - addi: ALU_OP 100, imm_s=1.
  - andi: ALU_OP 000, imm_s=0.
  - ori: ALU_OP 001, imm_s=0.
  - xori: ALU_OP 010, imm_s=0.
  - sltiu: ALU_OP 110, imm_s=1.
  - Goes to WB_I.
- WB_I: ALU controls held, Write_Reg=1, w_r_s=01, wr_data_s=0. Goes to FETCH.
- MEM_ADDR: ALU_OP=100, rt_imm_s=1, imm_s=1. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: address held. Goes to WB_LW.
- WB_LW: Write_Reg=1, w_r_s=01, wr_data_s=1. Goes to FETCH.
- MEM_WR: address held, Mem_Write=1. Goes to FETCH.
- BEQ: ALU_OP=101, rt_imm_s=0. PC_Write=ZF (Mealy on the live ZF), PC_s=01. Goes to FETCH.
- JUMP: PC_Write=1, PC_s=10. Goes to FETCH.
- Flag register: FR_ZF and FR_OF load the live ZF and OF on the rising edge that leaves EXEC_R, EXEC_I or BEQ. They are unchanged otherwise.

## Timing
- Reset (async): state=IDLE, FR_ZF=0, FR_OF=0, and all outputs 0 immediately.
- First FETCH is on the first rising edge after rst deasserts.
- Cycles per instruction, counted from FETCH:
  - R-type: 4.
  - I-type ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq: 3.
  - j: 3.
  - illegal: 2.
- Register write is committed on the edge that ends the WB state. The memory write is committed on the edge that ends MEM_WR.
- rst asserted mid-instruction aborts at once, with no further enables. Writes already committed stand. The instruction is not re-executed.
- beq with ZF=0 takes 3 cycles, and the PC holds the PC+4 value loaded in FETCH.
- Outputs depend on state only, except BEQ PC_Write, which depends on ZF.

## Test plan
- Reset with rst=1 mid-WB_R: state=0, Write_Reg=0, FR_ZF=FR_OF=0 without a clock edge. After release: state sequence 0,1,2.
- R add (OP=0, func=100000): states 1,2,3,4,1. ALU_OP=100 in EXEC_R/WB_R. Write_Reg=1, w_r_s=00 only in WB_R. A sub with equal operands leaves FR_ZF=1.
- addi and ori: EXEC_I gives addi ALU_OP=100, imm_s=1 and ori ALU_OP=001, imm_s=0, both with rt_imm_s=1. WB_I has w_r_s=01.
- lw then sw:
  - lw visits 7,8,9 with wr_data_s=1 in WB_LW.
  - sw visits 7,10 with Mem_Write=1 for exactly one cycle and Write_Reg=0 throughout.
- beq twice: with ZF=1, PC_Write=1 and PC_s=01 in BEQ. With ZF=0, PC_Write=0. Both take 3 cycles.
- j, then OP=111111, then OP=0 with func=001000:
  - j asserts PC_Write=1 with PC_s=10.
  - Both illegal cases pulse Illegal for 1 cycle in DECODE, return to FETCH, and produce no write enables.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back
// and driving every datapath enable and select, plus the ZF/OF flag register.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       ZF,
  input  logic       OF,
  output logic       PC_Write,
  output logic [1:0] PC_s,
  output logic       IR_Write,
  output logic       Write_Reg,
  output logic [1:0] w_r_s,
  output logic       wr_data_s,
  output logic       rt_imm_s,
  output logic       imm_s,
  output logic [2:0] ALU_OP,
  output logic       Mem_Write,
  output logic       FR_ZF,
  output logic       FR_OF,
  output logic       Illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_EXEC_I   = 4'd5;
  localparam logic [3:0] S_WB_I     = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_WB_LW    = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_BEQ      = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_q, state_d;
  logic       fr_zf_q, fr_zf_d, fr_of_q, fr_of_d;
  logic       r_ok, i_ok, i_imm_s;
  logic [2:0] r_alu_op, i_alu_op;

  // IR is stable after FETCH, so the instruction decode can feed every later state.
  always_comb begin
    r_ok     = 1'b1;
    r_alu_op = 3'b000;
    case (func)
      6'b100000: r_alu_op = 3'b100;
      6'b100010: r_alu_op = 3'b101;
      6'b100100: r_alu_op = 3'b000;
      6'b100101: r_alu_op = 3'b001;
      6'b100110: r_alu_op = 3'b010;
      6'b100111: r_alu_op = 3'b011;
      6'b101011: r_alu_op = 3'b110;
      6'b000100: r_alu_op = 3'b111;
      default:   r_ok     = 1'b0;
    endcase
    i_ok     = 1'b1;
    i_alu_op = 3'b000;
    i_imm_s  = 1'b0;
    case (OP)
      6'b001000: begin i_alu_op = 3'b100; i_imm_s = 1'b1; end
      6'b001100: i_alu_op = 3'b000;
      6'b001101: i_alu_op = 3'b001;
      6'b001110: i_alu_op = 3'b010;
      6'b001011: begin i_alu_op = 3'b110; i_imm_s = 1'b1; end
      default:   i_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (OP == OP_RTYPE && r_ok) state_d = S_EXEC_R;
        else if (i_ok)                   state_d = S_EXEC_I;
        else if (OP == OP_LW || OP == OP_SW) state_d = S_MEM_ADDR;
        else if (OP == OP_BEQ)           state_d = S_BEQ;
        else if (OP == OP_J)             state_d = S_JUMP;
        else                             state_d = S_FETCH;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_LW;
      S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BEQ, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Flags capture the ALU result on the edge leaving an ALU-evaluating state.
  always_comb begin
    fr_zf_d = fr_zf_q;
    fr_of_d = fr_of_q;
    if (state_q == S_EXEC_R || state_q == S_EXEC_I || state_q == S_BEQ) begin
      fr_zf_d = ZF;
      fr_of_d = OF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fr_zf_q <= 1'b0;
      fr_of_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fr_zf_q <= fr_zf_d;
      fr_of_q <= fr_of_d;
    end
  end

  always_comb begin
    PC_Write  = 1'b0;
    PC_s      = 2'b00;
    IR_Write  = 1'b0;
    Write_Reg = 1'b0;
    w_r_s     = 2'b00;
    wr_data_s = 1'b0;
    rt_imm_s  = 1'b0;
    imm_s     = 1'b0;
    ALU_OP    = 3'b000;
    Mem_Write = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin IR_Write = 1'b1; PC_Write = 1'b1; end
      S_DECODE: Illegal = (state_d == S_FETCH);
      S_EXEC_R: ALU_OP = r_alu_op;
      S_WB_R: begin ALU_OP = r_alu_op; Write_Reg = 1'b1; end
      S_EXEC_I: begin ALU_OP = i_alu_op; rt_imm_s = 1'b1; imm_s = i_imm_s; end
      S_WB_I: begin
        ALU_OP = i_alu_op; rt_imm_s = 1'b1; imm_s = i_imm_s;
        Write_Reg = 1'b1; w_r_s = 2'b01;
      end
      S_MEM_ADDR, S_MEM_RD: begin ALU_OP = 3'b100; rt_imm_s = 1'b1; imm_s = 1'b1; end
      S_WB_LW: begin Write_Reg = 1'b1; w_r_s = 2'b01; wr_data_s = 1'b1; end
      S_MEM_WR: begin
        ALU_OP = 3'b100; rt_imm_s = 1'b1; imm_s = 1'b1; Mem_Write = 1'b1;
      end
      S_BEQ: begin ALU_OP = 3'b101; PC_Write = ZF; PC_s = 2'b01; end
      S_JUMP: begin PC_Write = 1'b1; PC_s = 2'b10; end
      default: ;
    endcase
  end

  assign state = state_q;
  assign FR_ZF = fr_zf_q;
  assign FR_OF = fr_of_q;

endmodule
